// File: rtl/sdl_pkg.sv
// rtl/sdl_pkg.sv - shared constants and pointer/delay helpers for the sample delay line
package sdl_pkg;

    localparam int SDL_WIDTH     = 12;
    localparam int SDL_CHANNELS  = 2;
    localparam int SDL_MAX_DELAY = 64;
    localparam int SDL_ADDR_W    = $clog2(SDL_MAX_DELAY);

    // A depth-1 buffer still needs a one-bit address.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int clamp_delay(input int req, input int max_delay);
        return (req > max_delay) ? max_delay : req;
    endfunction

    function automatic int wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int wrap_sub(input int ptr, input int d, input int depth);
        return (ptr >= d) ? ptr - d : ptr + depth - d;
    endfunction

endpackage

// File: rtl/sdl_if.sv
// rtl/sdl_if.sv - sample stream, delay control and status bundle of the sample delay line
interface sdl_if #(
    parameter int DATA_W = 24,
    parameter int DW     = 7
);
    logic              clken_i;
    logic              dvalid_i;
    logic [DATA_W-1:0] data_i;
    logic              load_i;
    logic [DW-1:0]     delay_i;
    logic              dvalid_o;
    logic [DATA_W-1:0] data_o;
    logic              primed_o;
    logic [DW-1:0]     delay_o;

    modport master (
        output clken_i, dvalid_i, data_i, load_i, delay_i,
        input  dvalid_o, data_o, primed_o, delay_o
    );

    modport slave (
        input  clken_i, dvalid_i, data_i, load_i, delay_i,
        output dvalid_o, data_o, primed_o, delay_o
    );
endinterface

// File: rtl/sdl_ram.sv
// rtl/sdl_ram.sv - history RAM: one synchronous write port, one asynchronous (read-first) read port
module sdl_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees the pre-write contents, so a full-depth delay gets the oldest entry.
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sample_delay_line.sv
// rtl/sample_delay_line.sv - run-time programmable multi-channel delay counted in accepted samples
module sample_delay_line
    import sdl_pkg::*;
#(
    parameter int WIDTH     = SDL_WIDTH,
    parameter int CHANNELS  = SDL_CHANNELS,
    parameter int MAX_DELAY = SDL_MAX_DELAY,
    parameter int ZERO_FILL = 1
) (
    input logic clk,
    input logic rst_i,
    sdl_if.slave bus
);
    localparam int DW     = $clog2(MAX_DELAY + 1);
    localparam int AW     = addr_width(MAX_DELAY);
    localparam int DATA_W = WIDTH * CHANNELS;

    logic [DW-1:0]     d_q;
    logic [DW-1:0]     fill_q;
    logic [AW-1:0]     wr_ptr;
    logic              dvalid_q;
    logic [DATA_W-1:0] data_q;

    logic [DW-1:0]     d_eff;
    logic [DW-1:0]     fill_eff;
    logic [DW-1:0]     fill_nxt;
    logic              accept;
    logic              from_hist;
    logic              ram_we;
    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     wr_nxt;
    logic [DATA_W-1:0] rd_data;

    // A load takes effect before a coincident accept, so that sample primes under the new delay.
    always_comb begin
        d_eff    = d_q;
        fill_eff = fill_q;
        if (bus.load_i) begin
            d_eff    = DW'(clamp_delay(int'(bus.delay_i), MAX_DELAY));
            fill_eff = '0;
        end
        accept    = bus.clken_i & bus.dvalid_i & ~rst_i;
        from_hist = (fill_eff >= d_eff);
        fill_nxt  = from_hist ? fill_eff : fill_eff + 1'b1;
        ram_we    = accept && (d_eff != '0);
        rd_addr   = AW'(wrap_sub(int'(wr_ptr), int'(d_eff), MAX_DELAY));
        wr_nxt    = AW'(wrap_inc(int'(wr_ptr), MAX_DELAY));
    end

    sdl_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_DELAY),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst_i) begin
            d_q      <= DW'(MAX_DELAY);
            fill_q   <= '0;
            wr_ptr   <= '0;
            dvalid_q <= 1'b0;
            data_q   <= '0;
        end else if (!bus.clken_i) begin
            dvalid_q <= 1'b0;
        end else begin
            dvalid_q <= 1'b0;
            if (bus.load_i) begin
                d_q    <= d_eff;
                fill_q <= '0;
            end
            if (accept) begin
                fill_q <= fill_nxt;
                if (d_eff != '0) begin
                    wr_ptr <= wr_nxt;
                end
                if (from_hist) begin
                    dvalid_q <= 1'b1;
                    data_q   <= (d_eff == '0) ? bus.data_i : rd_data;
                end else if (ZERO_FILL != 0) begin
                    dvalid_q <= 1'b1;
                    data_q   <= '0;
                end
            end
        end
    end

    assign bus.dvalid_o = dvalid_q;
    assign bus.data_o   = data_q;
    assign bus.primed_o = (fill_q >= d_q);
    assign bus.delay_o  = d_q;
endmodule

// File: tb/tb_sample_delay_line.sv
// tb/tb_sample_delay_line.sv - scoreboard bench for zero-fill and suppressing builds of the delay line
module tb_sample_delay_line;
    localparam int MAXD = 64;

    typedef struct {
        int          cyc;
        logic [23:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdl_if #(.DATA_W(24), .DW(7)) if_zf ();
    sdl_if #(.DATA_W(24), .DW(7)) if_nz ();

    sample_delay_line #(.WIDTH(12), .CHANNELS(2), .MAX_DELAY(MAXD), .ZERO_FILL(1)) u_zf (
        .clk (clk), .rst_i (rst), .bus (if_zf)
    );
    sample_delay_line #(.WIDTH(12), .CHANNELS(2), .MAX_DELAY(MAXD), .ZERO_FILL(0)) u_nz (
        .clk (clk), .rst_i (rst), .bus (if_nz)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int nz_pulses = 0;
    bit mon_en = 1'b0;
    exp_t q_zf[$];
    exp_t q_nz[$];
    logic [23:0] hist[$];
    int m_d = MAXD;
    int m_cnt = 0;

    function automatic logic [23:0] sample(input int n);
        return {12'(n + 100), 12'(n)};
    endfunction

    // Drive one clock of stimulus into both builds and push what the specified behaviour predicts.
    task automatic step(input logic ce, input logic dv, input logic ld, input int dly,
                        input logic [23:0] din, input logic rs);
        exp_t e;
        if_zf.clken_i = ce; if_zf.dvalid_i = dv; if_zf.load_i = ld;
        if_zf.delay_i = 7'(dly); if_zf.data_i = din;
        if_nz.clken_i = ce; if_nz.dvalid_i = dv; if_nz.load_i = ld;
        if_nz.delay_i = 7'(dly); if_nz.data_i = din;
        rst = rs;
        if (rs) begin
            m_d = MAXD; m_cnt = 0; hist.delete();
        end else if (ce) begin
            if (ld) begin
                m_d = (dly > MAXD) ? MAXD : dly;
                m_cnt = 0;
            end
            if (dv) begin
                e.cyc = cyc + 1;
                if (m_cnt >= m_d) begin
                    e.data = (m_d == 0) ? din : hist[hist.size() - m_d];
                    q_zf.push_back(e);
                    q_nz.push_back(e);
                end else begin
                    e.data = '0;
                    q_zf.push_back(e);
                end
                if (m_d != 0) hist.push_back(din);
                if (m_cnt < m_d) m_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (q_zf.size() > 0 && q_zf[0].cyc == cyc) begin
                e = q_zf.pop_front();
                checks++;
                if (if_zf.dvalid_o !== 1'b1 || if_zf.data_o !== e.data) begin
                    errors++;
                    $display("FAIL zf_out cyc=%0d: got dvalid=%b data=%h, want dvalid=1 data=%h",
                             cyc, if_zf.dvalid_o, if_zf.data_o, e.data);
                end
            end else begin
                checks++;
                if (if_zf.dvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL zf_idle cyc=%0d: got dvalid=%b, want 0", cyc, if_zf.dvalid_o);
                end
            end
            if (if_nz.dvalid_o === 1'b1) nz_pulses++;
            if (q_nz.size() > 0 && q_nz[0].cyc == cyc) begin
                e = q_nz.pop_front();
                checks++;
                if (if_nz.dvalid_o !== 1'b1 || if_nz.data_o !== e.data) begin
                    errors++;
                    $display("FAIL nz_out cyc=%0d: got dvalid=%b data=%h, want dvalid=1 data=%h",
                             cyc, if_nz.dvalid_o, if_nz.data_o, e.data);
                end
            end else begin
                checks++;
                if (if_nz.dvalid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL nz_idle cyc=%0d: got dvalid=%b, want 0", cyc, if_nz.dvalid_o);
                end
            end
        end
    end

    task automatic test_reset();
        step(1, 0, 0, 0, '0, 1);
        step(1, 0, 0, 0, '0, 1);
        mon_en = 1'b1;
        checks++;
        if (if_zf.data_o !== 24'h0 || if_zf.dvalid_o !== 1'b0 || if_zf.primed_o !== 1'b0 ||
            if_zf.delay_o !== 7'd64) begin
            errors++;
            $display("FAIL reset_zf: got data=%h dv=%b primed=%b delay=%0d, want 0 0 0 64",
                     if_zf.data_o, if_zf.dvalid_o, if_zf.primed_o, if_zf.delay_o);
        end
        checks++;
        if (if_nz.data_o !== 24'h0 || if_nz.primed_o !== 1'b0 || if_nz.delay_o !== 7'd64) begin
            errors++;
            $display("FAIL reset_nz: got data=%h primed=%b delay=%0d, want 0 0 64",
                     if_nz.data_o, if_nz.primed_o, if_nz.delay_o);
        end
        step(1, 0, 0, 0, '0, 0);
    endtask

    task automatic test_zero_fill();
        step(1, 0, 1, 3, '0, 0);
        checks++;
        if (if_zf.delay_o !== 7'd3) begin
            errors++;
            $display("FAIL load_d3: got delay=%0d, want 3", if_zf.delay_o);
        end
        for (int n = 1; n <= 10; n++) begin
            step(1, 1, 0, 0, sample(n), 0);
            checks++;
            if (if_zf.primed_o !== (n >= 3)) begin
                errors++;
                $display("FAIL primed_d3 n=%0d: got %b, want %b", n, if_zf.primed_o, n >= 3);
            end
        end
        step(1, 0, 0, 0, '0, 0);
    endtask

    task automatic test_suppress();
        nz_pulses = 0;
        step(1, 0, 1, 5, '0, 0);
        for (int n = 1; n <= 12; n++) begin
            step(1, 1, 0, 0, sample(n + 20), 0);
            step(1, 0, 0, 0, '0, 0);
            step(1, 0, 0, 0, '0, 0);
        end
        checks++;
        if (nz_pulses !== 7) begin
            errors++;
            $display("FAIL nz_pulse_count: got %0d, want 7", nz_pulses);
        end
    endtask

    task automatic test_max_wrap();
        step(1, 0, 1, 64, '0, 0);
        for (int n = 0; n < 200; n++) step(1, 1, 0, 0, 24'($urandom), 0);
        checks++;
        if (if_zf.primed_o !== 1'b1 || if_nz.delay_o !== 7'd64) begin
            errors++;
            $display("FAIL max_primed: got primed=%b delay=%0d, want 1 64", if_zf.primed_o, if_nz.delay_o);
        end
        step(1, 0, 1, 0, '0, 0);
        checks++;
        if (if_nz.primed_o !== 1'b1 || if_nz.delay_o !== 7'd0) begin
            errors++;
            $display("FAIL d0_primed: got primed=%b delay=%0d, want 1 0", if_nz.primed_o, if_nz.delay_o);
        end
        for (int n = 0; n < 10; n++) step(1, 1, 0, 0, 24'($urandom), 0);
    endtask

    task automatic test_reload();
        step(1, 0, 1, 4, '0, 0);
        for (int n = 0; n < 8; n++) step(1, 1, 0, 0, 24'($urandom), 0);
        step(1, 1, 1, 2, 24'($urandom), 0);
        checks++;
        if (if_zf.delay_o !== 7'd2 || if_zf.primed_o !== 1'b0) begin
            errors++;
            $display("FAIL reload_d2: got delay=%0d primed=%b, want 2 0", if_zf.delay_o, if_zf.primed_o);
        end
        for (int n = 0; n < 6; n++) step(1, 1, 0, 0, 24'($urandom), 0);
        step(1, 0, 1, 100, '0, 0);
        checks++;
        if (if_zf.delay_o !== 7'd64 || if_nz.primed_o !== 1'b0) begin
            errors++;
            $display("FAIL clamp_100: got delay=%0d primed=%b, want 64 0", if_zf.delay_o, if_nz.primed_o);
        end
    endtask

    task automatic test_clken();
        step(1, 0, 1, 3, '0, 0);
        for (int n = 0; n < 5; n++) step(1, 1, 0, 0, 24'($urandom), 0);
        for (int n = 0; n < 10; n++) step(0, 1, 1, 7, 24'($urandom), 0);
        checks++;
        if (if_zf.delay_o !== 7'd3 || if_zf.primed_o !== 1'b1 || if_nz.delay_o !== 7'd3) begin
            errors++;
            $display("FAIL clken_hold: got delay=%0d primed=%b, want 3 1", if_zf.delay_o, if_zf.primed_o);
        end
        for (int n = 0; n < 5; n++) step(1, 1, 0, 0, 24'($urandom), 0);
    endtask

    task automatic test_reset_mid();
        step(1, 0, 1, 8, '0, 0);
        for (int n = 0; n < 12; n++) step(1, 1, 0, 0, 24'($urandom), 0);
        step(1, 1, 0, 0, 24'($urandom), 1);
        checks++;
        if (if_zf.data_o !== 24'h0 || if_zf.dvalid_o !== 1'b0 || if_zf.primed_o !== 1'b0 ||
            if_zf.delay_o !== 7'd64) begin
            errors++;
            $display("FAIL mid_reset: got data=%h dv=%b primed=%b delay=%0d, want 0 0 0 64",
                     if_zf.data_o, if_zf.dvalid_o, if_zf.primed_o, if_zf.delay_o);
        end
        for (int n = 1; n <= 70; n++) begin
            step(1, 1, 0, 0, 24'($urandom), 0);
            checks++;
            if (if_nz.primed_o !== (n >= 64)) begin
                errors++;
                $display("FAIL reprime n=%0d: got %b, want %b", n, if_nz.primed_o, n >= 64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_suppress();
        test_max_wrap();
        test_reload();
        test_clken();
        test_reset_mid();
        step(1, 0, 0, 0, '0, 0);
        step(1, 0, 0, 0, '0, 0);
        checks++;
        if (q_zf.size() != 0 || q_nz.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending outputs, want 0/0", q_zf.size(), q_nz.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
